// File: rtl/sleep_wdt_ctrl.sv
// Sleep / watchdog controller: free-running WDT with optional prescaler, SLEEP/WAKE
// sequencing and a fixed-length core reset pulse. Define SLEEP_WDT_WAKE_PIN_EN to let wakeIn exit SLEEP.
module sleep_wdt_ctrl #(
  parameter int WDT_BASE_WIDTH   = 8,
  parameter int RST_PULSE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wdtEnIn,
  input  logic       clrwdtIn,
  input  logic       sleepIn,
  input  logic       wakeIn,
  input  logic       psaIn,
  input  logic [2:0] psIn,
  output logic       coreHalt,
  output logic       wdtResetOut,
  output logic       toFlag,
  output logic       pdFlag,
  output logic [1:0] stateOut
);

  localparam int PULSE_W = (RST_PULSE_CYCLES > 1) ? $clog2(RST_PULSE_CYCLES) : 1;
  localparam logic [PULSE_W-1:0]        PULSE_LAST = PULSE_W'(RST_PULSE_CYCLES - 1);
  localparam logic [PULSE_W-1:0]        PULSE_ONE  = PULSE_W'(1);
  localparam logic [WDT_BASE_WIDTH-1:0] BASE_MAX   = '1;
  localparam logic [WDT_BASE_WIDTH-1:0] BASE_ONE   = WDT_BASE_WIDTH'(1);

  typedef enum logic [1:0] {
    ST_RUN    = 2'b00,
    ST_SLEEP  = 2'b01,
    ST_WAKE   = 2'b10,
    ST_WDTRST = 2'b11
  } state_t;

  state_t                    r_state;
  logic [WDT_BASE_WIDTH-1:0] r_base;
  logic [7:0]                r_presc;
  logic [PULSE_W-1:0]        r_pulse;
  logic                      r_to;
  logic                      r_pd;

  state_t                    w_state_nxt;
  logic [WDT_BASE_WIDTH-1:0] w_base_nxt;
  logic [WDT_BASE_WIDTH-1:0] w_base_adv;
  logic [7:0]                w_presc_nxt;
  logic [7:0]                w_presc_adv;
  logic [PULSE_W-1:0]        w_pulse_nxt;
  logic                      w_to_nxt;
  logic                      w_pd_nxt;
  logic                      w_counting;
  logic                      w_base_tick;
  logic                      w_timeout;
  logic                      w_wake;

  // Prescaler "ratio reached": low psIn bits all ones (psIn=0 always hits).
  function automatic logic f_presc_hit(input logic [7:0] presc, input logic [2:0] ps);
    logic [7:0] mask;
    mask = 8'((9'd1 << ps) - 9'd1);
    return (presc & mask) == mask;
  endfunction

`ifdef SLEEP_WDT_WAKE_PIN_EN
  assign w_wake = wakeIn;
`else
  logic w_unused_wake;
  assign w_unused_wake = wakeIn;
  assign w_wake        = 1'b0;
`endif

  assign w_counting  = wdtEnIn && ((r_state == ST_RUN) || (r_state == ST_SLEEP));
  assign w_base_tick = w_counting && (r_base == BASE_MAX);
  assign w_timeout   = w_base_tick && (!psaIn || f_presc_hit(r_presc, psIn));

  always_comb begin
    w_base_adv  = r_base;
    w_presc_adv = r_presc;
    if (!wdtEnIn) begin
      w_base_adv  = '0;
      w_presc_adv = '0;
    end else if (w_counting) begin
      w_base_adv = r_base + BASE_ONE;
      if (w_base_tick && psaIn) begin
        w_presc_adv = r_presc + 8'd1;
      end
    end
  end

  // Next-state: RUN priority is sleep > clear > timeout; SLEEP priority is timeout > wake.
  always_comb begin
    w_state_nxt = r_state;
    w_base_nxt  = w_base_adv;
    w_presc_nxt = w_presc_adv;
    w_pulse_nxt = r_pulse;
    w_to_nxt    = r_to;
    w_pd_nxt    = r_pd;
    case (r_state)
      ST_RUN: begin
        if (sleepIn) begin
          w_state_nxt = ST_SLEEP;
          w_base_nxt  = '0;
          w_presc_nxt = '0;
          w_to_nxt    = 1'b1;
          w_pd_nxt    = 1'b0;
        end else if (clrwdtIn) begin
          w_base_nxt  = '0;
          w_presc_nxt = '0;
          w_to_nxt    = 1'b1;
          w_pd_nxt    = 1'b1;
        end else if (w_timeout) begin
          w_state_nxt = ST_WDTRST;
          w_base_nxt  = '0;
          w_presc_nxt = '0;
          w_pulse_nxt = '0;
          w_to_nxt    = 1'b0;
        end
      end
      ST_SLEEP: begin
        if (w_timeout) begin
          w_state_nxt = ST_WDTRST;
          w_base_nxt  = '0;
          w_presc_nxt = '0;
          w_pulse_nxt = '0;
          w_to_nxt    = 1'b0;
        end else if (w_wake) begin
          w_state_nxt = ST_WAKE;
          w_to_nxt    = 1'b1;
          w_pd_nxt    = 1'b0;
        end
      end
      ST_WAKE: begin
        w_state_nxt = ST_RUN;
      end
      ST_WDTRST: begin
        w_base_nxt  = '0;
        w_presc_nxt = '0;
        if (r_pulse == PULSE_LAST) begin
          w_state_nxt = ST_RUN;
          w_pulse_nxt = '0;
        end else begin
          w_pulse_nxt = r_pulse + PULSE_ONE;
        end
      end
      default: begin
        w_state_nxt = ST_RUN;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_RUN;
      r_base  <= '0;
      r_presc <= '0;
      r_pulse <= '0;
      r_to    <= 1'b1;
      r_pd    <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_base  <= w_base_nxt;
      r_presc <= w_presc_nxt;
      r_pulse <= w_pulse_nxt;
      r_to    <= w_to_nxt;
      r_pd    <= w_pd_nxt;
    end
  end

  assign coreHalt    = (r_state != ST_RUN);
  assign wdtResetOut = (r_state == ST_WDTRST);
  assign toFlag      = r_to;
  assign pdFlag      = r_pd;
  assign stateOut    = r_state;

  a_wake_one_cycle: assert property (@(posedge clk) disable iff (rst)
    (r_state == ST_WAKE) |=> (r_state == ST_RUN));
  a_wdtrst_frozen: assert property (@(posedge clk) disable iff (rst)
    (r_state == ST_WDTRST) |-> (r_base == '0 && r_presc == '0));
  a_disabled_clear: assert property (@(posedge clk) disable iff (rst)
    !wdtEnIn |=> (r_base == '0 && r_presc == '0));

endmodule

// File: tb/tb_sleep_wdt_ctrl.sv
// Bench for sleep_wdt_ctrl: vector table, directed corner sequences, randomized run vs reference model.
module tb_sleep_wdt_ctrl;

  localparam int W      = 8;
  localparam int P      = 4;
  localparam int PERIOD = 1 << W;
  localparam int S_RUN  = 0;
  localparam int S_SLP  = 1;
  localparam int S_WAKE = 2;
  localparam int S_WDT  = 3;
`ifdef SLEEP_WDT_WAKE_PIN_EN
  localparam bit WAKE_EN = 1'b1;
`else
  localparam bit WAKE_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst, wdtEnIn, clrwdtIn, sleepIn, wakeIn, psaIn;
  logic [2:0] psIn;
  logic       coreHalt, wdtResetOut, toFlag, pdFlag;
  logic [1:0] stateOut;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  sleep_wdt_ctrl #(.WDT_BASE_WIDTH(W), .RST_PULSE_CYCLES(P)) dut (
    .clk(clk), .rst(rst), .wdtEnIn(wdtEnIn), .clrwdtIn(clrwdtIn), .sleepIn(sleepIn),
    .wakeIn(wakeIn), .psaIn(psaIn), .psIn(psIn), .coreHalt(coreHalt),
    .wdtResetOut(wdtResetOut), .toFlag(toFlag), .pdFlag(pdFlag), .stateOut(stateOut)
  );

  // Reference model: counts cycles with plain modular arithmetic.
  int m_st = S_RUN, m_base = 0, m_presc = 0, m_left = 0;
  bit m_to = 1'b1, m_pd = 1'b1;

  task automatic model_step();
    bit counting, tick, tmo;
    int nb, np, ratio;
    if (rst) begin
      m_st = S_RUN; m_base = 0; m_presc = 0; m_left = 0; m_to = 1'b1; m_pd = 1'b1;
      return;
    end
    ratio    = 1 << psIn;
    counting = wdtEnIn && (m_st == S_RUN || m_st == S_SLP);
    tick     = counting && ((m_base + 1) % PERIOD == 0);
    tmo      = tick && (!psaIn || (m_presc % ratio) == ratio - 1);
    nb = m_base;
    np = m_presc;
    if (!wdtEnIn) begin
      nb = 0; np = 0;
    end else if (counting) begin
      nb = (m_base + 1) % PERIOD;
      if (tick && psaIn) np = (m_presc + 1) % 256;
    end
    case (m_st)
      S_RUN: begin
        if (sleepIn) begin
          m_st = S_SLP; nb = 0; np = 0; m_to = 1'b1; m_pd = 1'b0;
        end else if (clrwdtIn) begin
          nb = 0; np = 0; m_to = 1'b1; m_pd = 1'b1;
        end else if (tmo) begin
          m_st = S_WDT; m_left = P; nb = 0; np = 0; m_to = 1'b0;
        end
      end
      S_SLP: begin
        if (tmo) begin
          m_st = S_WDT; m_left = P; nb = 0; np = 0; m_to = 1'b0;
        end else if (WAKE_EN && wakeIn) begin
          m_st = S_WAKE; m_to = 1'b1; m_pd = 1'b0;
        end
      end
      S_WAKE: m_st = S_RUN;
      default: begin
        nb = 0; np = 0;
        m_left--;
        if (m_left == 0) m_st = S_RUN;
      end
    endcase
    m_base  = nb;
    m_presc = np;
  endtask

  task automatic cyc();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply(input bit r, en, clr, slp, wk, psa, input int ps);
    rst = r; wdtEnIn = en; clrwdtIn = clr; sleepIn = slp; wakeIn = wk; psaIn = psa;
    psIn = 3'(ps);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int st, input int halt, input int rso,
                         input int to, input int pd);
    chk({tag, "_state"}, int'(stateOut), st);
    chk({tag, "_halt"}, int'(coreHalt), halt);
    chk({tag, "_rstout"}, int'(wdtResetOut), rso);
    chk({tag, "_to"}, int'(toFlag), to);
    chk({tag, "_pd"}, int'(pdFlag), pd);
  endtask

  typedef struct {
    bit rst, en, clr, slp, psa;
    int ps, n, st;
    bit halt, rso, to, pd;
  } vec_t;
  vec_t vecs[$];

  task automatic add(input bit r, en, clr, slp, psa, input int ps, n, st,
                     input bit halt, rso, to, pd);
    vec_t v;
    v.rst = r; v.en = en; v.clr = clr; v.slp = slp; v.psa = psa; v.ps = ps; v.n = n;
    v.st = st; v.halt = halt; v.rso = rso; v.to = to; v.pd = pd;
    vecs.push_back(v);
  endtask

  initial begin
    int n, seen, exp_st;
    apply(1, 0, 0, 0, 0, 0, 0);

    //   rst en clr slp psa ps  n    st     hlt rso to pd
    add(1, 0, 0, 0, 0, 0, 1,   S_RUN, 0, 0, 1, 1);
    add(0, 1, 0, 0, 0, 0, 255, S_RUN, 0, 0, 1, 1);
    add(0, 1, 0, 0, 0, 0, 1,   S_WDT, 1, 1, 0, 1);
    add(0, 1, 0, 0, 0, 0, 3,   S_WDT, 1, 1, 0, 1);
    add(0, 1, 0, 0, 0, 0, 1,   S_RUN, 0, 0, 0, 1);
    add(0, 1, 0, 1, 0, 0, 1,   S_SLP, 1, 0, 1, 0);
    add(0, 1, 0, 0, 0, 0, 255, S_SLP, 1, 0, 1, 0);
    add(0, 1, 0, 0, 0, 0, 1,   S_WDT, 1, 1, 0, 0);
    add(0, 1, 0, 0, 0, 0, 4,   S_RUN, 0, 0, 0, 0);
    add(0, 1, 1, 0, 0, 0, 1,   S_RUN, 0, 0, 1, 1);
    add(0, 0, 0, 0, 0, 0, 600, S_RUN, 0, 0, 1, 1);
    add(0, 1, 0, 0, 0, 0, 255, S_RUN, 0, 0, 1, 1);
    add(0, 1, 0, 0, 0, 0, 1,   S_WDT, 1, 1, 0, 1);
    add(0, 1, 0, 0, 0, 0, 1,   S_WDT, 1, 1, 0, 1);
    add(1, 1, 0, 0, 0, 0, 1,   S_RUN, 0, 0, 1, 1);
    add(0, 1, 0, 1, 0, 0, 1,   S_SLP, 1, 0, 1, 0);
    add(0, 1, 1, 0, 0, 0, 1,   S_SLP, 1, 0, 1, 0);
    add(0, 1, 0, 1, 0, 0, 1,   S_SLP, 1, 0, 1, 0);
    add(1, 1, 0, 0, 1, 0, 1,   S_RUN, 0, 0, 1, 1);
    add(0, 1, 0, 0, 1, 0, 255, S_RUN, 0, 0, 1, 1);
    add(0, 1, 0, 0, 1, 0, 1,   S_WDT, 1, 1, 0, 1);
    add(1, 1, 0, 0, 1, 1, 1,   S_RUN, 0, 0, 1, 1);
    add(0, 1, 0, 0, 1, 1, 511, S_RUN, 0, 0, 1, 1);
    add(0, 1, 0, 0, 1, 1, 1,   S_WDT, 1, 1, 0, 1);

    foreach (vecs[i]) begin
      apply(vecs[i].rst, vecs[i].en, vecs[i].clr, vecs[i].slp, 0, vecs[i].psa, vecs[i].ps);
      repeat (vecs[i].n) cyc();
      chk_all($sformatf("vec%0d", i), vecs[i].st, vecs[i].halt, vecs[i].rso,
              vecs[i].to, vecs[i].pd);
    end

    // Prescaler 1:4 timeout latency measured from a clear.
    apply(1, 0, 0, 0, 0, 0, 0); cyc();
    apply(0, 1, 0, 0, 0, 1, 2); repeat (100) cyc();
    clrwdtIn = 1; cyc(); clrwdtIn = 0;
    n = 0;
    while (!wdtResetOut && n < 2000) begin cyc(); n++; end
    chk("ps2_timeout_latency", n, 1024);

    // Clearing every 1000 cycles never times out.
    apply(1, 0, 0, 0, 0, 0, 0); cyc();
    apply(0, 1, 0, 0, 0, 1, 2);
    seen = 0;
    for (int k = 0; k < 5; k++) begin
      repeat (999) begin cyc(); if (wdtResetOut) seen++; end
      clrwdtIn = 1; cyc(); clrwdtIn = 0;
      chk("clr1000_to", int'(toFlag), 1);
    end
    chk("clr1000_no_wdtrst", seen, 0);

    // Clear coincident with timeout.
    apply(1, 0, 0, 0, 0, 0, 0); cyc();
    apply(0, 1, 0, 0, 0, 0, 0); repeat (255) cyc();
    clrwdtIn = 1; cyc(); clrwdtIn = 0;
    chk_all("clr_tmo", S_RUN, 0, 0, 1, 1);
    repeat (255) cyc();
    chk("clr_tmo_restart_state", int'(stateOut), S_RUN);
    cyc();
    chk("clr_tmo_next_tmo_state", int'(stateOut), S_WDT);

    // Sleep coincident with timeout.
    apply(1, 0, 0, 0, 0, 0, 0); cyc();
    apply(0, 1, 0, 0, 0, 0, 0); repeat (255) cyc();
    sleepIn = 1; cyc(); sleepIn = 0;
    chk_all("slp_tmo", S_SLP, 1, 0, 1, 0);
    repeat (255) cyc();
    chk("slp_tmo_still_sleep", int'(stateOut), S_SLP);
    cyc();
    chk_all("slp_tmo_wdt", S_WDT, 1, 1, 0, 0);

    // Wake pin at cycle 10 of SLEEP.
    apply(1, 0, 0, 0, 0, 0, 0); cyc();
    apply(0, 1, 0, 0, 0, 0, 0);
    sleepIn = 1; cyc(); sleepIn = 0;
    repeat (9) cyc();
    wakeIn = 1; cyc(); wakeIn = 0;
    exp_st = WAKE_EN ? S_WAKE : S_SLP;
    chk_all("wake1", exp_st, 1, 0, 1, 0);
    cyc();
    exp_st = WAKE_EN ? S_RUN : S_SLP;
    chk_all("wake2", exp_st, WAKE_EN ? 0 : 1, 0, 1, 0);

    // Wake coincident with timeout: timeout wins.
    apply(1, 0, 0, 0, 0, 0, 0); cyc();
    apply(0, 1, 0, 0, 0, 0, 0);
    sleepIn = 1; cyc(); sleepIn = 0;
    repeat (255) cyc();
    wakeIn = 1; cyc(); wakeIn = 0;
    chk_all("wake_tmo", S_WDT, 1, 1, 0, 0);

    // Randomized run against the reference model.
    apply(1, 1, 0, 0, 0, 0, 0); cyc();
    rst = 0;
    for (int i = 0; i < 8000; i++) begin
      if (i % 512 == 0) begin
        psaIn   = 1'($urandom % 2);
        psIn    = 3'($urandom % 3);
        wdtEnIn = ($urandom % 4) != 0;
      end
      rst      = ($urandom % 3000) == 0;
      clrwdtIn = ($urandom % 400) == 0;
      sleepIn  = ($urandom % 300) == 0;
      wakeIn   = ($urandom % 40) == 0;
      cyc();
      chk_all($sformatf("rnd%0d", i), m_st, int'(m_st != S_RUN), int'(m_st == S_WDT),
              int'(m_to), int'(m_pd));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
